// File: rtl/udp_axis_packetizer.sv
// Buffers an 8-bit AXIS byte stream and emits fixed-size UDP datagrams (short ones on timeout)
// through one udp_switch slot; RX traffic addressed to this slot is drained.
module udp_axis_packetizer #(
    parameter int unsigned UDP_PORT       = 1233,
    parameter int unsigned PAYLOAD_BYTES  = 256,
    parameter int unsigned FIFO_DEPTH     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 125000,
    parameter int unsigned IP_TTL         = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_axis_tdata,
    input  logic                          in_axis_tvalid,
    output logic                          in_axis_tready,
    output logic                          udp_tx_hdr_valid,
    input  logic                          udp_tx_hdr_ready,
    output logic [5:0]                    udp_tx_ip_dscp,
    output logic [1:0]                    udp_tx_ip_ecn,
    output logic [7:0]                    udp_tx_ip_ttl,
    output logic [31:0]                   udp_tx_ip_source_ip,
    output logic [31:0]                   udp_tx_ip_dest_ip,
    output logic [15:0]                   udp_tx_source_port,
    output logic [15:0]                   udp_tx_dest_port,
    output logic [15:0]                   udp_tx_length,
    output logic [15:0]                   udp_tx_checksum,
    output logic [7:0]                    udp_tx_payload_tdata,
    output logic                          udp_tx_payload_tvalid,
    input  logic                          udp_tx_payload_tready,
    output logic                          udp_tx_payload_tlast,
    output logic [0:0]                    udp_tx_payload_tuser,
    output logic                          udp_rx_hdr_ready,
    output logic                          udp_rx_payload_tready,
    input  logic [31:0]                   local_ip,
    input  logic [31:0]                   dest_ip,
    input  logic [15:0]                   dest_port,
    input  logic                          enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   packet_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] PKT_LVL  = LW'(PAYLOAD_BYTES);
    localparam logic [15:0]   PKT_LEN  = 16'(PAYLOAD_BYTES);
    localparam logic [31:0]   TO_LIM   = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   to_cnt;
    logic [15:0]   len;
    logic [15:0]   byte_cnt;
    logic [15:0]   start_len;
    logic          push;
    logic          pop;
    logic          partial;
    logic          full_start;
    logic          to_start;

    assign udp_rx_hdr_ready      = 1'b1;
    assign udp_rx_payload_tready = 1'b1;
    assign udp_tx_ip_dscp        = '0;
    assign udp_tx_ip_ecn         = '0;
    assign udp_tx_ip_ttl         = 8'(IP_TTL);
    assign udp_tx_source_port    = 16'(UDP_PORT);
    assign udp_tx_checksum       = '0;
    assign udp_tx_payload_tuser  = '0;

    assign in_axis_tready       = reset && (fifo_level < FULL_LVL);
    assign push                 = in_axis_tvalid && in_axis_tready;
    assign pop                  = udp_tx_payload_tvalid && udp_tx_payload_tready;
    assign udp_tx_payload_tdata = mem[rd_ptr];

    assign partial    = (fifo_level != '0) && (fifo_level < PKT_LVL);
    assign full_start = enable && (fifo_level >= PKT_LVL);
    assign to_start   = enable && (TO_LIM != '0) && partial && (to_cnt >= TO_LIM);
    assign start_len  = full_start ? PKT_LEN : 16'(fifo_level);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_axis_tdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            udp_tx_hdr_valid      <= 1'b0;
            udp_tx_payload_tvalid <= 1'b0;
            udp_tx_payload_tlast  <= 1'b0;
            udp_tx_ip_source_ip   <= '0;
            udp_tx_ip_dest_ip     <= '0;
            udp_tx_dest_port      <= '0;
            udp_tx_length         <= '0;
            len                   <= '0;
            byte_cnt              <= '0;
            to_cnt                <= '0;
            packet_count          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_start || to_start) begin
                        len                 <= start_len;
                        udp_tx_length       <= start_len + 16'd8;
                        udp_tx_ip_source_ip <= local_ip;
                        udp_tx_ip_dest_ip   <= dest_ip;
                        udp_tx_dest_port    <= dest_port;
                        udp_tx_hdr_valid    <= 1'b1;
                        to_cnt              <= '0;
                        state               <= HEADER;
                    // Any accepted byte restarts the idle count, so only a quiet input flushes.
                    end else if ((fifo_level == '0) || push) begin
                        to_cnt <= '0;
                    end else if (partial && (to_cnt != '1)) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                HEADER: begin
                    if (udp_tx_hdr_ready) begin
                        udp_tx_hdr_valid      <= 1'b0;
                        udp_tx_payload_tvalid <= 1'b1;
                        udp_tx_payload_tlast  <= (len == 16'd1);
                        byte_cnt              <= '0;
                        state                 <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (udp_tx_payload_tready) begin
                        if (udp_tx_payload_tlast) begin
                            udp_tx_payload_tvalid <= 1'b0;
                            udp_tx_payload_tlast  <= 1'b0;
                            packet_count          <= packet_count + 32'd1;
                            state                 <= IDLE;
                        end else begin
                            byte_cnt             <= byte_cnt + 16'd1;
                            udp_tx_payload_tlast <= ((byte_cnt + 16'd2) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/udp_axis_packetizer.md
Name: udp_axis_packetizer

Overview:
- Transmit-side counterpart of the UDP-to-AXIS master that feeds the DAC stream.
- Accepts an 8-bit AXIS byte stream (e.g. ADC samples) into an internal FIFO and emits fixed-size UDP datagrams to a configured destination.
- On timeout it flushes a short datagram. It attaches to one udp_switch mux slot, in the same way as udp_loopback and udp_spam.

Parameters:
- UDP_PORT, 1233, source UDP port; also the switch slot port. RX traffic to this port is drained.
- PAYLOAD_BYTES, 256, full datagram payload size in bytes (1..1472).
- FIFO_DEPTH, 1024, byte FIFO depth. Power of two, >= PAYLOAD_BYTES.
- TIMEOUT_CYCLES, 125000, idle cycles before a partial FIFO is flushed. 0 disables flushing.
- IP_TTL, 64, TTL placed in the header.

Ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- in_axis_if  AXIS_IF.Slave  8-bit  input byte stream. tlast and tuser are ignored.
- udp_tx_header_if  UDP_TX_HEADER_IF.Source  -  outgoing datagram header.
- udp_tx_payload_if  AXIS_IF.Master  8-bit, TUSER_WIDTH 1  outgoing payload.
- udp_rx_header_if  UDP_RX_HEADER_IF.Sink  -  hdr_ready tied 1 (drain).
- udp_rx_payload_if  AXIS_IF.Slave  -  tready tied 1 (drain).
- local_ip  input  32  source IP.
- dest_ip  input  32  destination IP.
- dest_port  input  16  destination UDP port.
- enable  input  1  permits starting new datagrams.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- packet_count  output  32  datagrams completed; wraps modulo 2^32.

Behaviour:
- Reset (reset=0, async) clears:
  - FIFO pointers, fifo_level, packet_count, timeout counter;
  - hdr_valid, payload tvalid, tlast, tuser;
  - state goes to IDLE.
- in tready is 0 during reset.
- FIFO:
  - in tready = (fifo_level < FIFO_DEPTH).
  - A push occurs on tvalid&tready.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Never overflows and never underflows.
- State IDLE:
  - When enable=1 and fifo_level >= PAYLOAD_BYTES, latch len = PAYLOAD_BYTES and go to HEADER next cycle.
  - When enable=1, TIMEOUT_CYCLES != 0, 0 < fifo_level < PAYLOAD_BYTES, and the timeout counter reaches TIMEOUT_CYCLES, latch len = fifo_level and go to HEADER.
  - Timeout counter:
    - increments each IDLE cycle while 0 < fifo_level < PAYLOAD_BYTES;
    - clears when leaving IDLE or when fifo_level is 0;
    - saturates (no wrap).
- State HEADER:
  - hdr_valid=1; fields held stable until the handshake:
    - ip_dscp=0, ip_ecn=0, ip_ttl=IP_TTL;
    - ip_source_ip=local_ip, ip_dest_ip=dest_ip;
    - source_port=UDP_PORT, dest_port=dest_port;
    - length=len+8 (16-bit), checksum=0.
  - local_ip, dest_ip and dest_port are sampled on HEADER entry.
  - On hdr_valid&hdr_ready, drop hdr_valid and go to PAYLOAD.
- State PAYLOAD:
  - tvalid=1 with tdata = FIFO head. Data is always present because len <= level at latch time.
  - A pop occurs on each tvalid&tready. A byte counter counts 0..len-1.
  - tlast=1 exactly on byte len-1. tuser=0 always.
  - When the last byte is accepted: packet_count+1, return to IDLE, tvalid=0 next cycle.
- Backpressure: tvalid, tdata and tlast stay stable while tready=0.
- Latency:
  - Threshold reached in IDLE -> hdr_valid high 1 cycle later.
  - Header handshake -> first payload tvalid 1 cycle later.
  - Minimum inter-datagram gap: 2 cycles.
- Enable deasserted in HEADER or PAYLOAD: the current datagram completes, and no new datagram starts. The FIFO keeps filling until full.
- Input is accepted in every state; pops happen only in PAYLOAD.
- Reset asserted mid-datagram: outputs drop immediately and FIFO contents are discarded. The downstream sees a truncated frame without tlast; this is acceptable.

Test Plan:
- 256 input bytes 0x00..0xFF, tready=1 downstream -> one header (length=264, dest_port as set, checksum=0), then 256 payload bytes in order, tlast on 0xFF, packet_count=1.
- 100 input bytes then idle, TIMEOUT_CYCLES=50 -> header length=108 after 50 idle cycles, 100 bytes, tlast on byte 100.
- Continuous input at 1 byte/cycle, payload tready toggling 50% -> datagrams of exactly 256 bytes; no byte lost, duplicated or reordered over 4096 bytes; tdata stable during stalls.
- Downstream hdr_ready=0 held, 1100 input bytes -> in tready drops after 1024 bytes accepted, fifo_level=1024; after release, 4 datagrams are sent and fifo_level returns to the remainder.
- enable=0 with 512 bytes buffered -> no hdr_valid. enable=1 -> 2 datagrams. enable cleared mid-payload -> the current datagram completes with tlast.
- reset pulled low during PAYLOAD byte 10 -> hdr_valid, tvalid, fifo_level and packet_count are 0 in the same cycle. After release, a fresh 256-byte input produces a correct datagram.
